voice_ram_scanner: RTL and testbench



---
 rtl/voice_ram_scanner.sv | 153 +++++++++++++++
 tb/tb_voice_ram_scanner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_ram_scanner.sv
// voice_ram_scanner
//   Sweeps entries 0..num_entries-1 of the voice-state RAM once per
//   sample_tick. Each word is registered and offered downstream on a
//   valid/ready stream. The scanner owns the RAM's single address port.
//   Host masked writes are muxed onto that port with absolute priority,
//   so they are never stalled.
//
//   Stream handshake: a beat transfers on any rising edge where both
//   out_valid and out_ready are high. Once out_valid is raised, it stays
//   high, and out_data/out_index/out_last stay stable, until that
//   transfer. Only reset can drop it earlier.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_tick           one-cycle frame start strobe
//   host_addr/din/mask/we host masked write request (always accepted)
//   ram_addr/din/mask/we  RAM port (host_addr when host_we, else idx)
//   ram_dout              RAM combinational read data for ram_addr
//   out_data/index/last   registered beat, its index, last-entry flag
//   out_valid, out_ready  stream handshake
//   busy                  frame in progress (state != IDLE)
//   overrun               sticky: tick seen while busy; cleared by reset
module voice_ram_scanner #(
  parameter int addr_width  = 8,
  parameter int data_width  = 8,
  parameter int num_entries = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [addr_width-1:0] host_addr,
  input  logic [data_width-1:0] host_din,
  input  logic [data_width-1:0] host_mask,
  input  logic                  host_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic [data_width-1:0] ram_mask,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_dout,
  output logic [data_width-1:0] out_data,
  output logic [addr_width-1:0] out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [addr_width-1:0] last_idx = addr_width'(num_entries - 1);
  localparam logic [addr_width-1:0] one_idx  = addr_width'(1);

  state_t                state;
  state_t                state_nxt;
  logic [addr_width-1:0] idx;

  // Control strobes decoded by the FSM for the datapath register block.
  logic start_frame;
  logic capture;
  logic release_beat;
  logic advance;

  // Host always wins the address port. A FETCH that collides with a
  // host write simply waits, so the data it then reads includes the write.
  assign ram_addr = host_we ? host_addr : idx;
  assign ram_din  = host_din;
  assign ram_mask = host_mask;
  assign ram_we   = host_we;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    start_frame  = 1'b0;
    capture      = 1'b0;
    release_beat = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          start_frame = 1'b1;
          state_nxt   = FETCH;
        end
      end
      FETCH: begin
        if (!host_we) begin
          capture   = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (out_valid && out_ready) begin
          release_beat = 1'b1;
          if (out_last) begin
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // advance is never raised on the last entry, so idx cannot wrap
      // even when num_entries covers the whole address space.
      if (start_frame) begin
        idx <= '0;
      end else if (advance) begin
        idx <= idx + one_idx;
      end

      if (capture) begin
        out_data  <= ram_dout;
        out_index <= idx;
        out_last  <= (idx == last_idx);
        out_valid <= 1'b1;
      end else if (release_beat) begin
        out_valid <= 1'b0;
      end

      // Any tick outside IDLE is dropped and flagged, including one that
      // coincides with the final handshake.
      if (sample_tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voice_ram_scanner.sv
module tb_voice_ram_scanner;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sample_tick;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic [DW-1:0] host_mask;
  logic          host_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_mask;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;

  voice_ram_scanner #(.addr_width(AW), .data_width(DW), .num_entries(N)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .host_addr(host_addr), .host_din(host_din), .host_mask(host_mask),
    .host_we(host_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_mask(ram_mask), .ram_we(ram_we), .ram_dout(ram_dout),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overrun(overrun)
  );

  // RAM environment: async read, masked synchronous write.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_mask) | (ram_din & ram_mask);
  end
  assign ram_dout = ram_mem[ram_addr];

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  bit            exp_overrun;
  int            n_tests = 0;
  int            n_fail  = 0;

  // frame scenario knobs
  int            stall_idx, stall_n, bp_idx, bp_n, mid_tick_cyc;
  bit            rand_ready, last_tick, present_write;
  logic [DW-1:0] stall_din, stall_mask;

  function automatic logic [DW-1:0] mwrite(input logic [DW-1:0] old_v,
                                           input logic [DW-1:0] din,
                                           input logic [DW-1:0] mask);
    return (old_v & ~mask) | (din & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_knobs();
    stall_idx = -1; stall_n = 0; bp_idx = -1; bp_n = 0; mid_tick_cyc = -1;
    rand_ready = 0; last_tick = 0; present_write = 0;
    stall_din = '0; stall_mask = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},   32'(out_valid), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_data"},    32'(out_data), 0);
    chk({tag, "_index"},   32'(out_index), 0);
    chk({tag, "_last"},    32'(out_last), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_overrun = 0;
    check_reset_outputs("reset");
    chk("reset_ram_addr", 32'(ram_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic host_write(input int addr, input logic [DW-1:0] din, input logic [DW-1:0] mask);
    @(negedge clk);
    host_addr = AW'(addr); host_din = din; host_mask = mask; host_we = 1'b1;
    #1;
    chk("hw_ram_addr", 32'(ram_addr), 32'(addr));
    chk("hw_ram_we",   32'(ram_we), 1);
    chk("hw_ram_din",  32'(ram_din), 32'(din));
    chk("hw_ram_mask", 32'(ram_mask), 32'(mask));
    ref_mem[addr] = mwrite(ref_mem[addr], din, mask);
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic run_frame();
    int w[N];
    int sum, exp_cycles, cyc, beat, stall_left;
    bit holding, done;
    logic [DW-1:0] d, held_d;
    logic [AW-1:0] held_i;
    sum = 0; cyc = 0; beat = 0; holding = 0; done = 0;
    held_d = '0; held_i = '0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      w[k] = rand_ready ? $urandom_range(0, 2) : ((k == bp_idx) ? bp_n : 0);
      sum += w[k];
      d = ref_mem[k];
      if (k == stall_idx && stall_n > 0) d = mwrite(d, stall_din, stall_mask);
      exp_q.push_back(d);
    end
    stall_left = (stall_idx >= 0) ? stall_n : 0;
    if (stall_left > 0) ref_mem[stall_idx] = mwrite(ref_mem[stall_idx], stall_din, stall_mask);
    exp_cycles = 2 * N + sum + stall_left;

    @(negedge clk);
    sample_tick = 1'b1;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      sample_tick = 1'b0; host_we = 1'b0; out_ready = 1'b0;
      if (!busy) begin
        done = 1;
      end else begin
        cyc++;
        #1;
        if (out_valid) begin
          if (!holding) begin
            if (exp_q.size() == 0) begin
              chk("extra_beat", 1, 0);
            end else begin
              d = exp_q.pop_front();
              chk("beat_data",  32'(out_data), 32'(d));
              chk("beat_index", 32'(out_index), 32'(beat));
              chk("beat_last",  32'(out_last), 32'(beat == N - 1));
            end
            held_d = out_data; held_i = out_index; holding = 1;
            if (present_write && beat == bp_idx) begin
              host_addr = AW'(beat); host_din = 8'h55; host_mask = 8'hFF; host_we = 1'b1;
              ref_mem[beat] = 8'h55;
            end
          end else begin
            chk("hold_data",  32'(out_data), 32'(held_d));
            chk("hold_index", 32'(out_index), 32'(held_i));
          end
          if (beat < N && w[beat] > 0) begin
            w[beat]--;
          end else begin
            out_ready = 1'b1;
            holding = 0;
            if (beat == N - 1 && last_tick) begin
              sample_tick = 1'b1;
              exp_overrun = 1;
            end
            beat++;
          end
        end else begin
          chk("fetch_addr", 32'(ram_addr), 32'(beat));
          if (beat == stall_idx && stall_left > 0) begin
            host_addr = AW'(stall_idx); host_din = stall_din; host_mask = stall_mask;
            host_we = 1'b1;
            stall_left--;
            #1;
            chk("stall_addr", 32'(ram_addr), 32'(stall_idx));
            chk("stall_we",   32'(ram_we), 1);
          end
        end
        if (cyc == mid_tick_cyc) begin
          sample_tick = 1'b1;
          exp_overrun = 1;
        end
      end
    end
    chk("frame_timeout", 32'(done), 1);
    chk("frame_cycles", 32'(cyc), 32'(exp_cycles));
    chk("frame_beats", 32'(beat), N);
    chk("frame_q_empty", 32'(exp_q.size()), 0);
    chk("frame_overrun", 32'(overrun), 32'(exp_overrun));
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy",  32'(busy), 0);
      chk("idle_valid", 32'(out_valid), 0);
    end
  endtask

  task automatic reset_mid_frame();
    bit hit;
    hit = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (out_valid && out_index == AW'(7)) hit = 1;
    end
    chk("mid_reset_reached_beat7", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    exp_overrun = 0;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; host_addr = '0; host_din = '0;
    host_mask = '0; host_we = 1'b0; out_ready = 1'b0;
    exp_overrun = 0;
    clear_knobs();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    do_reset();

    // preload RAM[i] = i + 0x10 through the host port
    for (int i = 0; i < N; i++) host_write(i, DW'(i + 16), 8'hFF);

    // plain sweep, ready always high
    run_frame();

    // masked write: 0xF0 then din 0x0F under mask 0x0C
    host_write(3, 8'hF0, 8'hFF);
    host_write(3, 8'h0F, 8'h0C);
    chk("model_masked_3", 32'(ref_mem[3]), 32'h0000_00FC);
    run_frame();

    // host stall on FETCH of entry 5
    clear_knobs();
    stall_idx = 5; stall_n = 3; stall_din = 8'hAA; stall_mask = 8'hFF;
    run_frame();

    // backpressure on beat 2, host rewrites entry 2 while it is held
    clear_knobs();
    bp_idx = 2; bp_n = 4; present_write = 1;
    run_frame();

    // overrun from a mid-frame tick; the entry-2 rewrite is now visible
    clear_knobs();
    mid_tick_cyc = 9;
    run_frame();

    // overrun from a tick on the final handshake
    do_reset();
    clear_knobs();
    last_tick = 1;
    run_frame();

    // randomized frames: random ready stalls and random host stalls
    for (int r = 0; r < 4; r++) begin
      clear_knobs();
      rand_ready = 1;
      stall_idx  = $urandom_range(0, N - 1);
      stall_n    = $urandom_range(1, 3);
      stall_din  = DW'($urandom_range(0, 255));
      stall_mask = DW'($urandom_range(0, 255));
      run_frame();
    end

    // reset mid-frame, then a fresh frame starting from index 0
    reset_mid_frame();
    clear_knobs();
    run_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
